// File: rtl/pulse_block_buffer.sv
// rtl/pulse_block_buffer.sv - per-sensor timestamped block store answering indexed block requests.
// Optional sticky overflow flag: define PULSE_BUFFER_OVERFLOW_EN.
module pulse_block_buffer #(
    parameter int DEPTH      = 64,
    parameter int HOLD_TICKS = 144000
) (
    input  logic        clk_72MHz,
    input  logic        reset,
    input  logic [23:0] sys_ts,
    input  logic [16:0] data_in,
    input  logic        data_valid,
    input  logic [7:0]  block_wanted_number,
    output logic [40:0] block_wanted,
    output logic        data_ready,
`ifdef PULSE_BUFFER_OVERFLOW_EN
    output logic        overflow,
`endif
    output logic [7:0]  avl_blocks_nb
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {EMPTY, FILLING, HOLD} state_t;

    state_t          state;
    logic [40:0]     mem [DEPTH];
    logic [40:0]     rd_data;
    logic [17:0]     hold_cnt;
    logic [7:0]      req_q;
    logic [7:0]      last_req;
    logic            rd_pending;
    logic            rd_oob;
    logic            full;
    logic            wr_en;
    logic            issue;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;

    assign full    = (avl_blocks_nb == 8'(DEPTH));
    assign wr_en   = data_valid && !full;
    assign issue   = (req_q != 8'd0) && (req_q != last_req);
    assign wr_addr = AW'(avl_blocks_nb);
    assign rd_addr = AW'(req_q - 8'd1);

    // A read issued to the slot being written is always out of range, so no bypass is needed.
    always_ff @(posedge clk_72MHz) begin
        if (wr_en)
            mem[wr_addr] <= {sys_ts, data_in};
        if (issue)
            rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk_72MHz or posedge reset) begin
        if (reset) begin
            state         <= EMPTY;
            hold_cnt      <= 18'd0;
            req_q         <= 8'd0;
            last_req      <= 8'd0;
            rd_pending    <= 1'b0;
            rd_oob        <= 1'b0;
            block_wanted  <= 41'd0;
            data_ready    <= 1'b0;
            avl_blocks_nb <= 8'd0;
`ifdef PULSE_BUFFER_OVERFLOW_EN
            overflow      <= 1'b0;
`endif
        end else begin
            req_q    <= block_wanted_number;
            last_req <= req_q;

            // A new index supersedes any read in flight; only the latest one completes.
            if (req_q == 8'd0) begin
                data_ready <= 1'b0;
                rd_pending <= 1'b0;
            end else if (issue) begin
                data_ready <= 1'b0;
                rd_pending <= 1'b1;
                rd_oob     <= (req_q > avl_blocks_nb);
            end else if (rd_pending) begin
                rd_pending   <= 1'b0;
                data_ready   <= 1'b1;
                block_wanted <= rd_oob ? 41'd0 : rd_data;
            end

            if (wr_en)
                avl_blocks_nb <= avl_blocks_nb + 8'd1;
            if (data_valid)
                hold_cnt <= 18'd0;
`ifdef PULSE_BUFFER_OVERFLOW_EN
            if (data_valid && full)
                overflow <= 1'b1;
`endif

            case (state)
                EMPTY: begin
                    if (wr_en)
                        state <= FILLING;
                end
                FILLING: begin
                    if (!data_valid) begin
                        if (hold_cnt == 18'(HOLD_TICKS))
                            state <= HOLD;
                        else
                            hold_cnt <= hold_cnt + 18'd1;
                    end
                end
                HOLD: begin
                    if (data_valid) begin
                        state <= FILLING;
                    end else if (block_wanted_number == 8'd0) begin
                        avl_blocks_nb <= 8'd0;
                        data_ready    <= 1'b0;
                        hold_cnt      <= 18'd0;
                        state         <= EMPTY;
`ifdef PULSE_BUFFER_OVERFLOW_EN
                        overflow      <= 1'b0;
`endif
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_block_buffer.sv
// tb/tb_pulse_block_buffer.sv - scoreboard bench for pulse_block_buffer.
module tb_pulse_block_buffer;

    localparam int DEPTH = 64;
    localparam int HOLD  = 200;

    logic        clk_72MHz = 1'b0;
    logic        reset;
    logic [23:0] sys_ts;
    logic [16:0] data_in;
    logic        data_valid;
    logic [7:0]  block_wanted_number;
    logic [40:0] block_wanted;
    logic        data_ready;
    logic [7:0]  avl_blocks_nb;
`ifdef PULSE_BUFFER_OVERFLOW_EN
    logic        overflow;
`endif

    int total = 0;
    int bad   = 0;
    logic [40:0] model_mem[$];
    logic [40:0] exp_q[$];

    pulse_block_buffer #(.DEPTH(DEPTH), .HOLD_TICKS(HOLD)) dut (
        .clk_72MHz(clk_72MHz),
        .reset(reset),
        .sys_ts(sys_ts),
        .data_in(data_in),
        .data_valid(data_valid),
        .block_wanted_number(block_wanted_number),
        .block_wanted(block_wanted),
        .data_ready(data_ready),
`ifdef PULSE_BUFFER_OVERFLOW_EN
        .overflow(overflow),
`endif
        .avl_blocks_nb(avl_blocks_nb)
    );

    always #7 clk_72MHz = ~clk_72MHz;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_72MHz);
            #1;
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        data_valid = 1'b0;
        block_wanted_number = 8'd0;
        data_in = 17'd0;
        sys_ts = 24'd0;
        #20;
        @(posedge clk_72MHz);
        #1 reset = 1'b0;
        model_mem.delete();
        exp_q.delete();
        tick(1);
    endtask

    task automatic write_word(input logic [23:0] ts, input logic [16:0] d);
        sys_ts = ts;
        data_in = d;
        data_valid = 1'b1;
        if (model_mem.size() < DEPTH)
            model_mem.push_back({ts, d});
        tick(1);
        data_valid = 1'b0;
    endtask

    function automatic logic [40:0] expect_block(input int idx);
        if (idx >= 1 && idx <= model_mem.size())
            return model_mem[idx-1];
        return 41'd0;
    endfunction

    task automatic read_check(input logic [7:0] idx, input string name);
        logic [40:0] e;
        block_wanted_number = idx;
        exp_q.push_back(expect_block(int'(idx)));
        tick(2);
        total++;
        if (data_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_early got=%b want=0", name, data_ready);
        end
        tick(1);
        total++;
        if (data_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready got=%b want=1", name, data_ready);
        end
        e = exp_q.pop_front();
        total++;
        if (block_wanted !== e) begin
            bad++;
            $display("FAIL %s_data got=%h want=%h", name, block_wanted, e);
        end
    endtask

    task automatic test_reset;
        do_reset();
        total++;
        if (data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", data_ready); end
        total++;
        if (avl_blocks_nb !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", avl_blocks_nb); end
        total++;
        if (block_wanted !== 41'd0) begin bad++; $display("FAIL reset_block got=%h want=0", block_wanted); end
`ifdef PULSE_BUFFER_OVERFLOW_EN
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
`endif
    endtask

    task automatic test_basic;
        logic [40:0] held;
        write_word(24'd100, 17'h00011);
        write_word(24'd200, 17'h00022);
        write_word(24'd300, 17'h00033);
        tick(1);
        total++;
        if (avl_blocks_nb !== 8'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", avl_blocks_nb); end
        read_check(8'd2, "basic_req2");
        total++;
        if (block_wanted !== {24'd200, 17'h00022}) begin
            bad++;
            $display("FAIL basic_const got=%h want=%h", block_wanted, {24'd200, 17'h00022});
        end
        tick(3);
        total++;
        if (data_ready !== 1'b1) begin bad++; $display("FAIL basic_stable got=%b want=1", data_ready); end
        read_check(8'd3, "basic_req3");
        held = expect_block(3);
        block_wanted_number = 8'd0;
        tick(2);
        total++;
        if (data_ready !== 1'b0) begin bad++; $display("FAIL basic_release got=%b want=0", data_ready); end
        total++;
        if (block_wanted !== held) begin bad++; $display("FAIL basic_hold got=%h want=%h", block_wanted, held); end
        read_check(8'd1, "basic_req1");
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 70; i++)
            write_word(24'(1000 + i), 17'(i + 1));
        tick(1);
        total++;
        if (avl_blocks_nb !== 8'd64) begin bad++; $display("FAIL full_count got=%0d want=64", avl_blocks_nb); end
        read_check(8'd64, "full_req64");
`ifdef PULSE_BUFFER_OVERFLOW_EN
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow got=%b want=1", overflow); end
`endif
        block_wanted_number = 8'd0;
        tick(2);
        read_check(8'd1, "full_req1");
    endtask

    task automatic test_restart;
        logic [40:0] e;
        do_reset();
        for (int i = 0; i < 4; i++)
            write_word(24'(10 * (i + 1)), 17'(17'h100 + i));
        tick(1);
        block_wanted_number = 8'd1;
        tick(1);
        block_wanted_number = 8'd3;
        exp_q.push_back(expect_block(3));
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            total++;
            if (k < 3) begin
                if (data_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL restart_early%0d got=%b want=0 block=%h", k, data_ready, block_wanted);
                end
            end else if (data_ready !== 1'b1) begin
                bad++;
                $display("FAIL restart_ready got=%b want=1", data_ready);
            end
        end
        e = exp_q.pop_front();
        total++;
        if (block_wanted !== e) begin bad++; $display("FAIL restart_data got=%h want=%h", block_wanted, e); end
        block_wanted_number = 8'd0;
        tick(2);
        read_check(8'd9, "oob_req9");
    endtask

    task automatic test_hold;
        int waited;
        do_reset();
        write_word(24'd5, 17'h0000A);
        write_word(24'd6, 17'h0000B);
        tick(HOLD);
        total++;
        if (avl_blocks_nb !== 8'd2) begin bad++; $display("FAIL hold_early_flush got=%0d want=2", avl_blocks_nb); end
        waited = 0;
        while (avl_blocks_nb !== 8'd0 && waited < 20) begin
            tick(1);
            waited++;
        end
        total++;
        if (avl_blocks_nb !== 8'd0) begin bad++; $display("FAIL hold_flush got=%0d want=0", avl_blocks_nb); end

        do_reset();
        write_word(24'd7, 17'h0000C);
        write_word(24'd8, 17'h0000D);
        block_wanted_number = 8'd1;
        tick(HOLD + 20);
        total++;
        if (avl_blocks_nb !== 8'd2) begin bad++; $display("FAIL hold_req_kept got=%0d want=2", avl_blocks_nb); end
        total++;
        if (data_ready !== 1'b1 || block_wanted !== {24'd7, 17'h0000C}) begin
            bad++;
            $display("FAIL hold_req_data got=%b/%h want=1/%h", data_ready, block_wanted, {24'd7, 17'h0000C});
        end
        block_wanted_number = 8'd0;
        tick(1);
        total++;
        if (avl_blocks_nb !== 8'd0 || data_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_release_flush got=%0d/%b want=0/0", avl_blocks_nb, data_ready);
        end
    endtask

    task automatic test_reset_mid_read;
        do_reset();
        write_word(24'd1, 17'h00001);
        write_word(24'd2, 17'h00002);
        write_word(24'd3, 17'h00003);
        read_check(8'd1, "mid_req1");
        block_wanted_number = 8'd2;
        tick(1);
        #3 reset = 1'b1;
        #1;
        total++;
        if (data_ready !== 1'b0) begin bad++; $display("FAIL async_ready got=%b want=0", data_ready); end
        total++;
        if (avl_blocks_nb !== 8'd0) begin bad++; $display("FAIL async_count got=%0d want=0", avl_blocks_nb); end
        block_wanted_number = 8'd0;
        tick(2);
        reset = 1'b0;
        tick(3);
        total++;
        if (data_ready !== 1'b0) begin bad++; $display("FAIL async_after got=%b want=0", data_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_restart();
        test_hold();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
